// File: rtl/uart_rx_words.sv
// ----------------------------------------------------------------------------
// uart_rx_words
//
// UART receiver that deserialises 8N1-style frames from `rx` and packs
// NUM_WORDS consecutive bytes into one W_IN-bit word. The word is offered
// downstream on a valid/ready stream. Byte 0 is the first byte received and
// lands in m_data_f[BITS_PER_WORD-1:0]. This matches the uart_tx stage, so a
// TX->RX loopback returns the original word.
//
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   : the stop bit is checked. A low stop bit drops the byte and the
//               partial word, pulses frame_err, and waits in BREAK until the
//               line returns high.
//   undefined : the stop-bit value is ignored and there is no frame_err port.
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   m_data_f   out  assembled word (registered, stable while stalled)
//   m_valid    out  m_data_f holds a complete word
//   m_ready    in   downstream accepts on m_valid && m_ready at posedge
//   overrun    out  one-cycle pulse: a completed word was dropped
//   frame_err  out  one-cycle pulse on a bad stop bit (macro builds only)
// ----------------------------------------------------------------------------
module uart_rx_words #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_IN             = 24
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rx,
    output logic [W_IN-1:0] m_data_f,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            overrun
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    output logic            frame_err
`endif
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int CNT_W     = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BIT_W     = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int BYTE_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic                     rx_meta_q,  rx_meta_d;
    logic                     rx_sync_q,  rx_sync_d;
    state_t                   state_q,    state_d;
    logic [CNT_W-1:0]         clk_cnt_q,  clk_cnt_d;
    logic [BIT_W-1:0]         bit_cnt_q,  bit_cnt_d;
    logic [BYTE_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [BITS_PER_WORD-1:0] shift_q,    shift_d;
    logic [W_IN-1:0]          staging_q,  staging_d;
    logic                     word_done_q, word_done_d;
    logic [W_IN-1:0]          m_data_q,   m_data_d;
    logic                     m_valid_q,  m_valid_d;
    logic                     overrun_q,  overrun_d;
`ifdef UART_RX_FRAME_CHECK_EN
    logic                     frame_err_q, frame_err_d;
`endif

    logic rxs_s;

    assign rxs_s    = rx_sync_q;
    assign m_data_f = m_data_q;
    assign m_valid  = m_valid_q;
    assign overrun  = overrun_q;
`ifdef UART_RX_FRAME_CHECK_EN
    assign frame_err = frame_err_q;
`endif

    // Next-state logic: synchroniser, frame FSM, word staging and output handshake.
    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        staging_d   = staging_q;
        word_done_d = 1'b0;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        frame_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rxs_s) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            // Sample mid start bit; a high line here was only a glitch.
            S_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (rxs_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            // LSB first: new bits enter at the top and shift towards bit 0.
            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxs_s, shift_q[BITS_PER_WORD-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (!rxs_s) begin
                        byte_cnt_d  = '0;
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else
`endif
                    begin
                        for (int n = 0; n < NUM_WORDS; n++) begin
                            staging_d[n*BITS_PER_WORD +: BITS_PER_WORD] =
                                (byte_cnt_q == BYTE_W'(n)) ? shift_q
                                                           : staging_q[n*BITS_PER_WORD +: BITS_PER_WORD];
                        end
                        if (byte_cnt_q == BYTE_LAST) begin
                            byte_cnt_d  = '0;
                            word_done_d = 1'b1;
                        end else begin
                            byte_cnt_d  = byte_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

`ifdef UART_RX_FRAME_CHECK_EN
            // Hold off until the line is released so a long low is not
            // mistaken for a new start bit.
            S_BREAK: begin
                if (rxs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
`endif

            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        // A finished word loads only if the output slot is free or being
        // drained this same cycle; otherwise it is dropped and flagged.
        if (word_done_q) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = staging_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            staging_q   <= '0;
            word_done_q <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            staging_q   <= staging_d;
            word_done_q <= word_done_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_FRAME_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_words.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_words
//
// Bench for uart_rx_words at CLOCKS_PER_PULSE=4, 8-bit frames, 24-bit words.
// A serial transmitter model drives rx; expected words are computed from the
// transmitted byte lists (byte k weighted by 256**k). A monitor records every
// handshake, counts overrun/frame_err pulse cycles and checks that a stalled
// word stays put.
// ----------------------------------------------------------------------------
module tb_uart_rx_words;

    localparam int CPP = 4;
    localparam int BPW = 8;
    localparam int W   = 24;
    localparam int NW  = W / BPW;

    logic         clk     = 1'b0;
    logic         rstn    = 1'b0;
    logic         rx      = 1'b1;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data_f;
    logic         m_valid;
    logic         overrun;
`ifdef UART_RX_FRAME_CHECK_EN
    logic         frame_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    int           ovr_cnt  = 0;
    int           ferr_cnt = 0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] data_prev = '0;

    uart_rx_words #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .W_IN            (W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .m_data_f (m_data_f),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .overrun  (overrun)
`ifdef UART_RX_FRAME_CHECK_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: samples just after each negedge, when inputs are settled for the next posedge.
    always begin
        @(negedge clk);
        #1;
        if (hold_prev && rstn) begin
            n_checks++;
            if (m_valid === 1'b1 && m_data_f === data_prev) n_pass++;
            else $display("FAIL stall_stable: got valid=%b data=%h, required valid=1 data=%h",
                          m_valid, m_data_f, data_prev);
        end
        if (rstn && m_valid === 1'b1 && m_ready) got_q.push_back(m_data_f);
        if (rstn && overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_FRAME_CHECK_EN
        if (rstn && frame_err === 1'b1) ferr_cnt++;
`endif
        hold_prev = rstn && (m_valid === 1'b1) && !m_ready;
        data_prev = m_data_f;
    end

    // Serial transmitter model; must be called right after a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < BPW; i++) begin
            rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends NW random bytes and appends the word they should form to exp_q.
    task automatic send_random_word(output logic [W-1:0] w);
        logic [7:0] b;
        w = '0;
        for (int k = 0; k < NW; k++) begin
            b = 8'($urandom_range(0, 255));
            w = w + (W'(b) << (8 * k));
            send_byte(b, 1'b1);
        end
    endtask

    // Sends a word byte by byte, lowest byte first.
    task automatic send_word(input logic [W-1:0] w);
        for (int k = 0; k < NW; k++) send_byte(8'((w / (24'd1 << (8 * k))) % 24'd256), 1'b1);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        rx      = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (m_valid === 1'b0) n_pass++;
        else $display("FAIL reset_valid: got %b, required 0", m_valid);
        n_checks++;
        if (m_data_f === 24'h000000) n_pass++;
        else $display("FAIL reset_data: got %h, required 000000", m_data_f);
        n_checks++;
        if (overrun === 1'b0) n_pass++;
        else $display("FAIL reset_overrun: got %b, required 0", overrun);
`ifdef UART_RX_FRAME_CHECK_EN
        n_checks++;
        if (frame_err === 1'b0) n_pass++;
        else $display("FAIL reset_frame_err: got %b, required 0", frame_err);
`endif
    endtask

    task automatic test_loopback();
        logic [W-1:0] w;
        got_q.delete(); exp_q.delete(); ovr_cnt = 0;
        m_ready = 1'b1;
        send_word(24'h0F3CA5);
        exp_q.push_back(24'h0F3CA5);
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == 1 && got_q[0] === 24'h0F3CA5) n_pass++;
        else $display("FAIL loopback_fixed: got %0d words first=%h, required 1 word 0f3ca5",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx);
        for (int r = 0; r < 5; r++) begin
            send_random_word(w);
            exp_q.push_back(w);
            idle($urandom_range(1, 3 * CPP));
        end
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == exp_q.size()) n_pass++;
        else $display("FAIL loopback_count: got %0d, required %0d", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] === exp_q[i]) n_pass++;
            else $display("FAIL loopback_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
        n_checks++;
        if (ovr_cnt == 0) n_pass++;
        else $display("FAIL loopback_overrun: got %0d pulses, required 0", ovr_cnt);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        got_q.delete(); exp_q.delete(); ovr_cnt = 0;
        m_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            send_random_word(w);
            exp_q.push_back(w);
        end
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == exp_q.size()) n_pass++;
        else $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] === exp_q[i]) n_pass++;
            else $display("FAIL b2b_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
    endtask

    task automatic test_glitch();
        got_q.delete();
        m_ready = 1'b1;
        rx = 1'b0;
        @(negedge clk);
        idle(3 * CPP);
        n_checks++;
        if (got_q.size() == 0 && m_valid === 1'b0) n_pass++;
        else $display("FAIL glitch_nothing: got %0d words valid=%b, required 0 words valid=0",
                      got_q.size(), m_valid);
        send_word(24'h112233);
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == 1 && got_q[0] === 24'h112233) n_pass++;
        else $display("FAIL glitch_next_word: got %0d words first=%h, required 1 word 112233",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx);
    endtask

    task automatic test_overrun();
        got_q.delete(); ovr_cnt = 0;
        m_ready = 1'b0;
        send_word(24'hAAAAAA);
        send_word(24'h555555);
        idle(2 * CPP);
        n_checks++;
        if (m_valid === 1'b1 && m_data_f === 24'hAAAAAA) n_pass++;
        else $display("FAIL overrun_hold: got valid=%b data=%h, required valid=1 data=aaaaaa",
                      m_valid, m_data_f);
        n_checks++;
        if (ovr_cnt == 1) n_pass++;
        else $display("FAIL overrun_pulse: got %0d cycles, required 1", ovr_cnt);
        m_ready = 1'b1;
        idle(4 * CPP);
        n_checks++;
        if (got_q.size() == 1 && got_q[0] === 24'hAAAAAA && m_valid === 1'b0) n_pass++;
        else $display("FAIL overrun_drain: got %0d handshakes valid=%b, required 1 of aaaaaa valid=0",
                      got_q.size(), m_valid);
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        got_q.delete(); ovr_cnt = 0;
        m_ready = 1'b0;
        send_random_word(wa);
        idle(2 * CPP);
        send_random_word(wb);
        // Stop sample lands on the next posedge; the load decision one cycle later.
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == 1 && got_q[0] === wa) n_pass++;
        else $display("FAIL simul_first: got %0d handshakes first=%h, required 1 of %h",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx, wa);
        n_checks++;
        if (m_valid === 1'b1 && m_data_f === wb) n_pass++;
        else $display("FAIL simul_load: got valid=%b data=%h, required valid=1 data=%h",
                      m_valid, m_data_f, wb);
        n_checks++;
        if (ovr_cnt == 0) n_pass++;
        else $display("FAIL simul_overrun: got %0d, required 0", ovr_cnt);
        m_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        m_ready = 1'b0;
        send_random_word(w);
        send_byte(8'h5A, 1'b1);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPP) @(negedge clk);
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_valid === 1'b0 && m_data_f === 24'h000000 && overrun === 1'b0) n_pass++;
        else $display("FAIL midreset_outputs: got valid=%b data=%h ovr=%b, required 0/000000/0",
                      m_valid, m_data_f, overrun);
        rstn = 1'b1;
        idle(4 * CPP);
        got_q.delete(); ovr_cnt = 0;
        n_checks++;
        if (m_valid === 1'b0) n_pass++;
        else $display("FAIL midreset_no_valid: got %b, required 0", m_valid);
        m_ready = 1'b1;
        send_random_word(w);
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == 1 && got_q[0] === w) n_pass++;
        else $display("FAIL midreset_next_word: got %0d words first=%h, required 1 of %h",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx, w);
    endtask

`ifdef UART_RX_FRAME_CHECK_EN
    task automatic test_frame_check();
        got_q.delete(); ferr_cnt = 0;
        m_ready = 1'b1;
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        idle(4 * CPP);
        n_checks++;
        if (ferr_cnt == 1) n_pass++;
        else $display("FAIL frame_err_pulse: got %0d cycles, required 1", ferr_cnt);
        n_checks++;
        if (got_q.size() == 0 && m_valid === 1'b0) n_pass++;
        else $display("FAIL frame_no_word: got %0d words valid=%b, required 0", got_q.size(), m_valid);
        send_word(24'h010203);
        idle(2 * CPP);
        n_checks++;
        if (got_q.size() == 1 && got_q[0] === 24'h010203) n_pass++;
        else $display("FAIL frame_next_word: got %0d words first=%h, required 1 word 010203",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx);
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
`ifdef UART_RX_FRAME_CHECK_EN
        test_frame_check();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
